// File: rtl/button_conditioner_pkg.sv
// ============================================================================
// Module : button_conditioner_pkg
// Brief  : Shared button bit indices and default timing constants for the
//          button conditioner and the downstream cursor logic.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package button_conditioner_pkg;

  localparam int BTN_LEFT  = 0;
  localparam int BTN_YINC  = 1;
  localparam int BTN_YDEC  = 2;
  localparam int BTN_RIGHT = 3;

  localparam int NUM_BUTTONS = 4;

  localparam int DEFAULT_DEBOUNCE_CYCLES = 250000;
  localparam int DEFAULT_REPEAT_DELAY    = 12500000;
  localparam int DEFAULT_REPEAT_PERIOD   = 2500000;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/button_conditioner_debounce_channel.sv
// ============================================================================
// Module : debounce_channel
// Brief  : One button: 2-FF synchronizer, debounce counter, press strobe and,
//          with BUTTON_AUTO_REPEAT_EN defined, hold-to-repeat strobes.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module debounce_channel
  import button_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
`ifdef BUTTON_AUTO_REPEAT_EN
  ,
  parameter int REPEAT_DELAY    = DEFAULT_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEFAULT_REPEAT_PERIOD
`endif
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_n,
  output logic move_n,
  output logic held
);

  localparam int            c_CW      = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [c_CW-1:0] c_DB_LAST = c_CW'(DEBOUNCE_CYCLES - 1);

  logic            r_sync1;
  logic            r_sync2;
  logic            r_stable;
  logic [c_CW-1:0] r_cnt;
  logic            r_move_n;
  logic            r_held;

  logic            w_accept;
  logic            w_press;
  logic            w_release;
  logic            w_rep_fire;

  // A new level is accepted on the edge that completes the stable run.
  assign w_accept  = (r_sync2 != r_stable) && (r_cnt == c_DB_LAST);
  assign w_press   = w_accept & ~r_sync2;
  assign w_release = w_accept &  r_sync2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1  <= 1'b1;
      r_sync2  <= 1'b1;
      r_stable <= 1'b1;
      r_cnt    <= '0;
      r_move_n <= 1'b1;
      r_held   <= 1'b0;
    end else begin
      r_sync1  <= btn_n;
      r_sync2  <= r_sync1;
      r_move_n <= ~(w_press | w_rep_fire);
      if (r_sync2 == r_stable) begin
        r_cnt <= '0;
      end else if (w_accept) begin
        r_stable <= r_sync2;
        r_held   <= ~r_sync2;
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + c_CW'(1);
      end
    end
  end

`ifdef BUTTON_AUTO_REPEAT_EN
  localparam int              c_RW     = $clog2(max_int(REPEAT_DELAY, REPEAT_PERIOD) + 1);
  localparam logic [c_RW-1:0] c_DELAY  = c_RW'(REPEAT_DELAY);
  localparam logic [c_RW-1:0] c_PERIOD = c_RW'(REPEAT_PERIOD);

  logic [c_RW-1:0] r_rcnt;
  logic            r_rfirst;

  // r_rcnt holds the number of edges since the last press or repeat strobe.
  assign w_rep_fire = r_held && !w_release &&
                      (r_rcnt == (r_rfirst ? c_DELAY : c_PERIOD));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rcnt   <= '0;
      r_rfirst <= 1'b0;
    end else if (w_press) begin
      r_rcnt   <= c_RW'(1);
      r_rfirst <= 1'b1;
    end else if (!r_held || w_release) begin
      r_rcnt   <= '0;
      r_rfirst <= 1'b0;
    end else if (w_rep_fire) begin
      r_rcnt   <= c_RW'(1);
      r_rfirst <= 1'b0;
    end else begin
      r_rcnt   <= r_rcnt + c_RW'(1);
    end
  end
`else
  assign w_rep_fire = 1'b0;
`endif

  assign move_n = r_move_n;
  assign held   = r_held;

endmodule

`default_nettype wire

// File: rtl/button_conditioner.sv
// ============================================================================
// Module : button_conditioner
// Brief  : Four independent debounced, active-low single-cycle move strobes.
//          Optional auto-repeat enabled by defining BUTTON_AUTO_REPEAT_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module button_conditioner
  import button_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEFAULT_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEFAULT_REPEAT_PERIOD
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] btn_n,
  output logic [3:0] move_n,
  output logic [3:0] held
);

  if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_param_check
    $error("button_conditioner: timing parameters must be >= 1");
  end

  for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_chan
    debounce_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
`ifdef BUTTON_AUTO_REPEAT_EN
      ,
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD)
`endif
    ) u_chan (
      .clk    (clk),
      .rst    (rst),
      .btn_n  (btn_n[i]),
      .move_n (move_n[i]),
      .held   (held[i])
    );
  end

endmodule

`default_nettype wire

// File: tb/tb_button_conditioner.sv
// ============================================================================
// Module : tb_button_conditioner
// Brief  : Randomized and directed bench for button_conditioner against a
//          window-based reference model (BUTTON_AUTO_REPEAT_EN aware).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_button_conditioner;

  localparam int c_DB     = 4;
  localparam int c_DELAY  = 10;
  localparam int c_PERIOD = 5;

  logic       clk;
  logic       rst;
  logic [3:0] btn_n;
  logic [3:0] move_n;
  logic [3:0] held;

  int checks   = 0;
  int failures = 0;

  button_conditioner #(
    .DEBOUNCE_CYCLES (c_DB),
    .REPEAT_DELAY    (c_DELAY),
    .REPEAT_PERIOD   (c_PERIOD)
  ) u_dut (
    .clk    (clk),
    .rst    (rst),
    .btn_n  (btn_n),
    .move_n (move_n),
    .held   (held)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: a level is accepted once the last c_DB synchronized
  // samples (raw input delayed two edges) all disagree with the current level.
  logic [3:0] m_stable;
  logic [3:0] m_pipe[$];
  logic [3:0] m_hist[$];
  int         m_edge;
  int         m_press[4];
  logic [3:0] exp_move;
  logic [3:0] exp_held;
  int         strobe_cnt;
  logic [3:0] last_strobe;

  task automatic model_reset();
    m_stable = 4'hF;
    m_pipe.delete();
    m_pipe.push_back(4'hF);
    m_pipe.push_back(4'hF);
    m_hist.delete();
    m_edge   = 0;
    exp_move = 4'hF;
    exp_held = 4'h0;
  endtask

  task automatic model_edge(input logic [3:0] b);
    logic [3:0] s2v;
    logic [3:0] h;
    bit         flip;
    int         d;
    s2v = m_pipe.pop_front();
    m_pipe.push_back(b);
    m_hist.push_back(s2v);
    if (m_hist.size() > c_DB) void'(m_hist.pop_front());
    m_edge++;
    exp_move = 4'hF;
    for (int i = 0; i < 4; i++) begin
      flip = (m_hist.size() == c_DB);
      foreach (m_hist[k]) begin
        h = m_hist[k];
        if (h[i] == m_stable[i]) flip = 1'b0;
      end
      if (flip) begin
        m_stable[i] = ~m_stable[i];
        if (m_stable[i] == 1'b0) begin
          exp_move[i] = 1'b0;
          m_press[i]  = m_edge;
        end
      end else if (m_stable[i] == 1'b0) begin
        d = m_edge - m_press[i];
`ifdef BUTTON_AUTO_REPEAT_EN
        if (d == c_DELAY || (d > c_DELAY && (d - c_DELAY) % c_PERIOD == 0))
          exp_move[i] = 1'b0;
`endif
      end
    end
    exp_held = ~m_stable;
  endtask

  task automatic tick();
    logic [3:0] b;
    b = btn_n;
    @(posedge clk);
    if (rst) model_reset();
    else     model_edge(b);
    #1;
    check("move_n", 32'(move_n), 32'(exp_move));
    check("held", 32'(held), 32'(exp_held));
    if (move_n != 4'hF) begin
      strobe_cnt++;
      last_strobe = move_n;
    end
  endtask

  task automatic hold(input logic [3:0] v, input int n);
    btn_n = v;
    repeat (n) tick();
  endtask

  // Assert reset between edges, check the asynchronous clear, then release.
  task automatic do_reset(input int n);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check("rst_move_n", 32'(move_n), 32'hF);
    check("rst_held", 32'(held), 32'h0);
    repeat (n) tick();
    rst = 1'b0;
  endtask

  initial begin
    rst   = 1'b1;
    btn_n = 4'hF;
    strobe_cnt  = 0;
    last_strobe = 4'hF;
    model_reset();
    @(posedge clk);
    #1;
    check("reset_move_n", 32'(move_n), 32'hF);
    check("reset_held", 32'(held), 32'h0);
    rst = 1'b0;
    hold(4'hF, 5);

    // Clean press on the right button
    strobe_cnt = 0;
    hold(4'b0111, 30);
    hold(4'hF, 10);
`ifdef BUTTON_AUTO_REPEAT_EN
    check("clean_cnt", 32'(strobe_cnt), 32'd5);
`else
    check("clean_cnt", 32'(strobe_cnt), 32'd1);
`endif
    check("clean_val", 32'(last_strobe), 32'(4'b0111));

    // Bouncing left button
    strobe_cnt = 0;
    hold(4'b1110, 2);
    hold(4'hF, 1);
    hold(4'b1110, 3);
    hold(4'hF, 1);
    hold(4'b1110, 12);
    hold(4'hF, 10);
`ifdef BUTTON_AUTO_REPEAT_EN
    check("bounce_cnt", 32'(strobe_cnt), 32'd2);
`else
    check("bounce_cnt", 32'(strobe_cnt), 32'd1);
`endif
    check("bounce_val", 32'(last_strobe), 32'(4'b1110));

    // Simultaneous y+1 / y-1
    strobe_cnt = 0;
    hold(4'b1001, 8);
    hold(4'hF, 10);
    check("simul_cnt", 32'(strobe_cnt), 32'd1);
    check("simul_val", 32'(last_strobe), 32'(4'b1001));

    // Reset mid-debounce with the left button held
    strobe_cnt = 0;
    hold(4'b1110, 2);
    do_reset(3);
    hold(4'b1110, 8);
    hold(4'hF, 10);
    check("rst_cnt", 32'(strobe_cnt), 32'd1);

`ifdef BUTTON_AUTO_REPEAT_EN
    strobe_cnt = 0;
    hold(4'b0111, 40);
    hold(4'hF, 10);
    check("repeat_cnt", 32'(strobe_cnt), 32'd7);
`endif

    // Randomized segments: bounces, long holds, multi-button, random resets
    for (int s = 0; s < 400; s++) begin
      if ($urandom_range(0, 39) == 0) do_reset($urandom_range(1, 3));
      if ($urandom_range(0, 3) == 0) hold(4'($urandom), $urandom_range(15, 40));
      else                            hold(4'($urandom), $urandom_range(1, 8));
    end
    hold(4'hF, 10);
    check("final_held", 32'(held), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
